// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - single-entry instruction register with load/clear/hold
module fetch_buffer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end; FETCH_PERF_EN adds perf counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            Stall_i,
    input  logic            MemStall_i,
    input  logic            Branch_i,
    input  logic [XLEN-1:0] BranchTarget_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] PC_o,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_bubble_o,
`endif
    output logic [XLEN-1:0] instr_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic            buf_load;
    logic            buf_clear;
    logic            redirect;
    logic [XLEN-1:0] buf_data;

    assign redirect = Branch_i && !MemStall_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;

        // Acks are honoured even under MemStall_i so none is ever lost.
        unique case (state_q)
            IDLE: begin
                if (start_i && !MemStall_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack_i) begin
                    if (!redirect) begin
                        state_d  = READY;
                        buf_load = 1'b1;
                    end
                end else if (redirect) begin
                    state_d     = DROP;
                    drop_addr_d = pc_q;
                end
            end
            READY: begin
                if (!MemStall_i) begin
                    if (Branch_i) begin
                        state_d = FETCH;
                    end else if (!Stall_i) begin
                        state_d   = FETCH;
                        pc_d      = pc_q + XLEN'(PC_INC);
                        buf_clear = 1'b1;
                    end
                end
            end
            DROP: begin
                if (imem_ack_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_d      = BranchTarget_i;
            buf_clear = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    fetch_buffer #(
        .XLEN(XLEN)
    ) u_buffer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (buf_load),
        .clear_i(buf_clear),
        .data_i (imem_data_i),
        .data_o (buf_data)
    );

    // While dropping, the abandoned request keeps its original address.
    assign imem_req_o  = (state_q == FETCH) || (state_q == DROP);
    assign imem_addr_o = (state_q == DROP) ? drop_addr_q : pc_q;
    assign PC_o        = pc_q;
    assign instr_o     = (state_q == READY) ? buf_data : XLEN'(NOP);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_bubble_q;
    logic        consume;
    logic        bubble;

    assign consume = (state_q == READY) && !MemStall_i && !Branch_i && !Stall_i;
    assign bubble  = (state_q != IDLE) && (instr_o == XLEN'(NOP));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_q + 32'(consume);
            perf_bubble_q <= perf_bubble_q + 32'(bubble);
        end
    end

    assign perf_fetch_o  = perf_fetch_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a random-latency memory
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        Stall_i = 1'b0;
    logic        MemStall_i = 1'b0;
    logic        Branch_i = 1'b0;
    logic [31:0] BranchTarget_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] PC_o;
    logic [31:0] instr_o;

    always #5 clk_i = ~clk_i;

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .Stall_i       (Stall_i),
        .MemStall_i    (MemStall_i),
        .Branch_i      (Branch_i),
        .BranchTarget_i(BranchTarget_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .PC_o          (PC_o),
        .instr_o       (instr_o)
    );

    int errors = 0;
    int checks = 0;
    int consumed = 0;
    int mem_lat_fix = 2;
    bit mon_en = 1'b0;
    logic [31:0] exp_q[$];

    // Every instruction word is nonzero and encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2] ^ 30'h155A_3C3F, 2'b11};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: ack 0..3 cycles (or a fixed latency) after a request is first seen.
    bit mbusy = 1'b0;
    int mcnt = 0;
    always @(posedge clk_i) begin
        #1;
        imem_ack_i  = 1'b0;
        imem_data_i = $urandom();
        if (!rst_i || !imem_req_o) begin
            mbusy = 1'b0;
        end else begin
            if (!mbusy) begin
                mbusy = 1'b1;
                mcnt  = (mem_lat_fix >= 0) ? mem_lat_fix : int'($urandom_range(0, 3));
            end
            if (mcnt == 0) begin
                imem_ack_i  = 1'b1;
                imem_data_i = mem_word(imem_addr_o);
                mbusy       = 1'b0;
            end else begin
                mcnt--;
            end
        end
    end

    // Monitor: compares each consumed instruction with the model's next PC.
    bit          p_valid = 1'b0;
    bit          p_req, p_ack, p_hold;
    logic [31:0] p_addr, p_instr, p_pc, mon_e;
    always @(negedge clk_i) begin
        if (mon_en && rst_i) begin
            if (p_valid && p_req && !p_ack) begin
                check("req_held", 32'(imem_req_o), 32'd1);
                check("addr_stable", imem_addr_o, p_addr);
            end
            if (p_valid && p_hold) begin
                check("hold_instr", instr_o, p_instr);
                check("hold_pc", PC_o, p_pc);
            end
            if (instr_o != 32'h0) begin
                check("instr_data", instr_o, mem_word(PC_o));
                check("ready_no_req", 32'(imem_req_o), 32'd0);
                if (!Stall_i && !MemStall_i && !Branch_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL consume_unexpected: got pc %h expected none", PC_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("consume_pc", PC_o, mon_e);
                        exp_q.push_back(mon_e + 32'd4);
                    end
                    consumed++;
                end
            end
            p_valid = 1'b1;
            p_req   = imem_req_o;
            p_ack   = imem_ack_i;
            p_addr  = imem_addr_o;
            p_instr = instr_o;
            p_pc    = PC_o;
            p_hold  = (instr_o != 32'h0) && (MemStall_i || (Stall_i && !Branch_i));
        end else begin
            p_valid = 1'b0;
        end
    end

    // Inputs set here take effect at the following posedge.
    task automatic drive(input bit st, input bit ms, input bit br, input logic [31:0] tgt);
        @(posedge clk_i);
        #1;
        Stall_i        = st;
        MemStall_i     = ms;
        Branch_i       = br;
        BranchTarget_i = tgt;
        if (br && !ms) begin
            exp_q.delete();
            exp_q.push_back(tgt);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (instr_o == 32'h0) begin
            if (n >= 40) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: got no instruction after %0d cycles expected one", n);
                return;
            end
            drive(1'b1, 1'b0, 1'b0, '0);
            n++;
        end
    endtask

    int          n;
    logic [31:0] cap_instr, cap_pc, tgt;
    bit          seen;

    initial begin
        #12;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_pc", PC_o, RST_PC);
        check("rst_instr", instr_o, 32'h0);

        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        exp_q.push_back(RST_PC);
        mon_en = 1'b1;
        repeat (2) begin
            drive(1'b0, 1'b0, 1'b0, '0);
            check("idle_no_req", 32'(imem_req_o), 32'd0);
        end

        start_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        start_i = 1'b0;
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, RST_PC);
        wait_ready(n);
        check("fetch_latency", 32'(n), 32'd3);
        check("first_pc", PC_o, RST_PC);

        cap_instr = instr_o;
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            check("stall_instr", instr_o, cap_instr);
            check("stall_pc", PC_o, RST_PC);
            check("stall_no_req", 32'(imem_req_o), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("wrap_req", 32'(imem_req_o), 32'd1);
        check("wrap_addr", imem_addr_o, 32'h0);

        wait_ready(n);
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        wait_ready(n);
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("fetch8_addr", imem_addr_o, 32'h8);
        drive(1'b0, 1'b0, 1'b1, 32'h40);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("drop_req", 32'(imem_req_o), 32'd1);
        check("drop_addr", imem_addr_o, 32'h8);
        wait_ready(n);
        check("branch_pc", PC_o, 32'h40);

        drive(1'b0, 1'b1, 1'b1, 32'h100);
        cap_instr = instr_o;
        cap_pc    = PC_o;
        drive(1'b0, 1'b1, 1'b1, 32'h100);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("memstall_instr", instr_o, cap_instr);
        check("memstall_pc", PC_o, cap_pc);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("after_memstall_addr", imem_addr_o, 32'h44);

        mem_lat_fix = -1;
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom();
            tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 11) == 0), tgt);
        end
        repeat (20) drive(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (consumed < 100) begin
            errors++;
            $display("FAIL consume_count: got %0d expected at least 100", consumed);
        end

        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (imem_req_o) seen = 1'b1;
            else drive(1'b0, 1'b0, 1'b0, '0);
        end
        check("pre_reset_req", 32'(seen), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req_o), 32'd0);
        check("async_rst_instr", instr_o, 32'h0);
        check("async_rst_pc", PC_o, RST_PC);
        check("async_rst_addr", imem_addr_o, RST_PC);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
